// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// ----------------
// Shares one 8-bit memory bus between requester A (CPU core) and requester B
// (video/DMA fetch). Each access is a fixed two-cycle slot against a
// synchronous-read RAM:
//   ADDR cycle : o_addr/o_data/o_wr are presented; the RAM samples them (and
//                writes when o_wr=1) at the closing edge.
//   DATA cycle : i_data carries the read data; it is captured at the closing
//                edge, and the next winner is picked at the same edge.
//
// Handshake: a requester raises i_req_x with i_wr_x/i_addr_x/i_wdata_x and
// holds all four stable until o_gnt_x is seen (a one-cycle pulse marking
// acceptance). The cycle after the grant it either presents its next request
// or drops i_req_x; a request still high in the DATA cycle is a new request.
// Reads complete with a one-cycle o_rvalid_x pulse; writes complete at grant.
//
// Optional build macro: ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, B over A (A can starve under continuous B)
//   defined   : on a tie the port that was not served last wins
//
// Ports
//   clk_25          : system clock (25 MHz), the only clock
//   rst             : synchronous active-high reset
//   i_req_x/i_wr_x/i_addr_x/i_wdata_x : requester x access request
//   o_gnt_x         : request accepted pulse
//   o_rdata_x       : read data, held until the next read for that port
//   o_rvalid_x      : read data valid pulse
//   i_data          : RAM read data (valid the cycle after the address)
//   o_addr/o_data/o_wr : RAM address, write data, write strobe
//   dbg_state       : current FSM state (0 IDLE, 1 ADDR, 2 DATA)
//   dbg_last_served : port granted most recently (0 A, 1 B)
module mem_bus_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk_25,
  input  logic              rst,
  input  logic              i_req_a,
  input  logic              i_wr_a,
  input  logic [ADDR_W-1:0] i_addr_a,
  input  logic [DATA_W-1:0] i_wdata_a,
  output logic              o_gnt_a,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic              o_rvalid_a,
  input  logic              i_req_b,
  input  logic              i_wr_b,
  input  logic [ADDR_W-1:0] i_addr_b,
  input  logic [DATA_W-1:0] i_wdata_b,
  output logic              o_gnt_b,
  output logic [DATA_W-1:0] o_rdata_b,
  output logic              o_rvalid_b,
  input  logic [DATA_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_wr,
  output logic [1:0]        dbg_state,
  output logic              dbg_last_served
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state;
  logic   owner;        // 0 = A, 1 = B: port whose slot is in flight
  logic   owner_rd;     // slot in flight is a read
  logic   last_served;  // 0 = A, 1 = B

  logic any_req;
  logic win_b;

  always_comb begin
    any_req = i_req_a | i_req_b;
`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, B wins only if A was served last.
    win_b = i_req_b & (~i_req_a | ~last_served);
`else
    win_b = i_req_b;
`endif
  end

  always_ff @(posedge clk_25) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      owner_rd    <= 1'b0;
      last_served <= 1'b1;
      o_addr      <= '0;
      o_data      <= '0;
      o_wr        <= 1'b0;
      o_gnt_a     <= 1'b0;
      o_gnt_b     <= 1'b0;
      o_rvalid_a  <= 1'b0;
      o_rvalid_b  <= 1'b0;
      o_rdata_a   <= '0;
      o_rdata_b   <= '0;
    end else begin
      o_gnt_a    <= 1'b0;
      o_gnt_b    <= 1'b0;
      o_rvalid_a <= 1'b0;
      o_rvalid_b <= 1'b0;
      case (state)
        ADDR: begin
          // RAM takes the access at this edge; requests are not looked at.
          o_wr  <= 1'b0;
          state <= DATA;
        end
        default: begin
          // IDLE and DATA both arbitrate; DATA also retires a read first,
          // so back-to-back slots run with no idle cycle between them.
          if (state == DATA && owner_rd) begin
            if (owner) begin
              o_rdata_b  <= i_data;
              o_rvalid_b <= 1'b1;
            end else begin
              o_rdata_a  <= i_data;
              o_rvalid_a <= 1'b1;
            end
          end
          if (any_req) begin
            o_addr      <= win_b ? i_addr_b  : i_addr_a;
            o_data      <= win_b ? i_wdata_b : i_wdata_a;
            o_wr        <= win_b ? i_wr_b    : i_wr_a;
            owner_rd    <= win_b ? ~i_wr_b   : ~i_wr_a;
            o_gnt_a     <= ~win_b;
            o_gnt_b     <= win_b;
            owner       <= win_b;
            last_served <= win_b;
            state       <= ADDR;
          end else begin
            // o_addr/o_data keep their last value while idle.
            o_wr  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign dbg_state       = state;
  assign dbg_last_served = last_served;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  // clock / reset
  logic clk_25 = 1'b0;
  logic rst    = 1'b1;
  always #20 clk_25 = ~clk_25;

  logic              i_req_a = 1'b0, i_wr_a = 1'b0;
  logic [ADDR_W-1:0] i_addr_a = '0;
  logic [DATA_W-1:0] i_wdata_a = '0;
  logic              i_req_b = 1'b0, i_wr_b = 1'b0;
  logic [ADDR_W-1:0] i_addr_b = '0;
  logic [DATA_W-1:0] i_wdata_b = '0;
  logic              o_gnt_a, o_rvalid_a, o_gnt_b, o_rvalid_b, o_wr;
  logic [DATA_W-1:0] o_rdata_a, o_rdata_b, o_data;
  logic [DATA_W-1:0] i_data = '0;
  logic [ADDR_W-1:0] o_addr;
  logic [1:0]        dbg_state;
  logic              dbg_last_served;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_25(clk_25), .rst(rst),
    .i_req_a(i_req_a), .i_wr_a(i_wr_a), .i_addr_a(i_addr_a), .i_wdata_a(i_wdata_a),
    .o_gnt_a(o_gnt_a), .o_rdata_a(o_rdata_a), .o_rvalid_a(o_rvalid_a),
    .i_req_b(i_req_b), .i_wr_b(i_wr_b), .i_addr_b(i_addr_b), .i_wdata_b(i_wdata_b),
    .o_gnt_b(o_gnt_b), .o_rdata_b(o_rdata_b), .o_rvalid_b(o_rvalid_b),
    .i_data(i_data), .o_addr(o_addr), .o_data(o_data), .o_wr(o_wr),
    .dbg_state(dbg_state), .dbg_last_served(dbg_last_served)
  );

  // synchronous-read RAM (read-before-write)
  logic [DATA_W-1:0] mem [0:65535];
  int wr_cycles = 0;
  always @(posedge clk_25) begin
    if (o_wr) begin
      mem[o_addr] <= o_data;
      wr_cycles++;
    end
    i_data <= mem[o_addr];
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk_25);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_state"}, dbg_state, 0);
    check_eq({tag, "_last"}, dbg_last_served, 1);
    check_eq({tag, "_addr"}, o_addr, 0);
    check_eq({tag, "_data"}, o_data, 0);
    check_eq({tag, "_wr"}, o_wr, 0);
    check_eq({tag, "_gnts"}, {o_gnt_a, o_gnt_b}, 0);
    check_eq({tag, "_rvalids"}, {o_rvalid_a, o_rvalid_b}, 0);
    check_eq({tag, "_rdata_a"}, o_rdata_a, 0);
    check_eq({tag, "_rdata_b"}, o_rdata_b, 0);
  endtask

  task automatic read_a(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    i_req_a = 1'b1; i_wr_a = 1'b0; i_addr_a = addr;
    step();
    check_eq({tag, "_gnt"}, {o_gnt_a, o_gnt_b}, 2'b10);
    check_eq({tag, "_addr"}, o_addr, addr);
    check_eq({tag, "_wr"}, o_wr, 0);
    i_req_a = 1'b0;
    step();
    check_eq({tag, "_mid"}, {o_gnt_a, o_rvalid_a}, 0);
    step();
    check_eq({tag, "_rvalid"}, {o_rvalid_a, o_rvalid_b}, 2'b10);
    check_eq({tag, "_rdata"}, o_rdata_a, exp);
    step();
    check_eq({tag, "_rvalid_end"}, o_rvalid_a, 0);
    check_eq({tag, "_rdata_hold"}, o_rdata_a, exp);
  endtask

  initial begin
    logic [7:0] b2b_data [4];
    int wr_snap;
    int rv_count;
    b2b_data = '{8'h10, 8'h21, 8'h32, 8'h43};
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1234] = 8'h5A;
    mem[16'h0000] = 8'h10;
    mem[16'h0001] = 8'h21;
    mem[16'h0002] = 8'h32;
    mem[16'h0003] = 8'h43;

    do_reset();
    check_reset_vals("reset");

    // 1: single A read
    read_a("a_read", 16'h1234, 8'h5A);
    check_eq("a_read_no_wr", wr_cycles, 0);

    // 2: B write, then read it back from A
    i_req_b = 1'b1; i_wr_b = 1'b1; i_addr_b = 16'h8000; i_wdata_b = 8'hC3;
    step();
    check_eq("b_wr_gnt", {o_gnt_a, o_gnt_b}, 2'b01);
    check_eq("b_wr_strobe", o_wr, 1);
    check_eq("b_wr_addr", o_addr, 16'h8000);
    check_eq("b_wr_data", o_data, 8'hC3);
    i_req_b = 1'b0; i_wr_b = 1'b0;
    step();
    check_eq("b_wr_strobe_off", o_wr, 0);
    step();
    check_eq("b_wr_no_rvalid", {o_rvalid_a, o_rvalid_b}, 0);
    check_eq("b_wr_one_cycle", wr_cycles, 1);
    read_a("a_readback", 16'h8000, 8'hC3);

    // 3/4: both ports requesting from reset
    do_reset();
    i_req_a = 1'b1; i_wr_a = 1'b0; i_addr_a = 16'h0001;
    i_req_b = 1'b1; i_wr_b = 1'b0; i_addr_b = 16'h0002;
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("rr_gnt", {o_gnt_a, o_gnt_b}, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k > 0) begin
        if (k % 2 == 1) begin
          check_eq("rr_rvalid_a", {o_rvalid_a, o_rvalid_b}, 2'b10);
          check_eq("rr_rdata_a", o_rdata_a, 8'h21);
        end else begin
          check_eq("rr_rvalid_b", {o_rvalid_a, o_rvalid_b}, 2'b01);
          check_eq("rr_rdata_b", o_rdata_b, 8'h32);
        end
      end
      if (k == 3) begin
        i_req_a = 1'b0;
        i_req_b = 1'b0;
      end
      step();
      check_eq("rr_addr_nogrant", {o_gnt_a, o_gnt_b}, 0);
    end
    step();
    check_eq("rr_last_gnt", {o_gnt_a, o_gnt_b}, 0);
    check_eq("rr_last_rvalid_b", {o_rvalid_a, o_rvalid_b}, 2'b01);
    check_eq("rr_last_rdata_b", o_rdata_b, 8'h32);
`else
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("prio_gnt_b", {o_gnt_a, o_gnt_b}, 2'b01);
      if (k > 0) begin
        check_eq("prio_rvalid_b", {o_rvalid_a, o_rvalid_b}, 2'b01);
        check_eq("prio_rdata_b", o_rdata_b, 8'h32);
      end
      if (k == 2) i_req_b = 1'b0;
      step();
      check_eq("prio_addr_nogrant", {o_gnt_a, o_gnt_b}, 0);
    end
    step();
    check_eq("prio_gnt_a", {o_gnt_a, o_gnt_b}, 2'b10);
    check_eq("prio_last_served", dbg_last_served, 0);
    check_eq("prio_rvalid_b_last", {o_rvalid_a, o_rvalid_b}, 2'b01);
    i_req_a = 1'b0;
    step();
    step();
    check_eq("prio_rvalid_a", {o_rvalid_a, o_rvalid_b}, 2'b10);
    check_eq("prio_rdata_a", o_rdata_a, 8'h21);
`endif
    step();
    check_eq("arb_idle", dbg_state, 0);

    // 5: back-to-back A reads of 0..3
    rv_count = 0;
    i_req_a = 1'b1; i_wr_a = 1'b0; i_addr_a = 16'h0000;
    for (int s = 1; s <= 10; s++) begin
      logic exp_gnt;
      logic exp_rv;
      step();
      exp_gnt = (s % 2 == 1) && (s <= 7);
      exp_rv  = (s % 2 == 1) && (s >= 3) && (s <= 9);
      check_eq("b2b_gnt", o_gnt_a, exp_gnt);
      check_eq("b2b_rvalid", o_rvalid_a, exp_rv);
      if (exp_gnt) begin
        exp_q.push_back(b2b_data[(s - 1) / 2]);
        if (s == 7) i_req_a = 1'b0;
        else i_addr_a = i_addr_a + 16'd1;
      end
      if (o_rvalid_a) begin
        rv_count++;
        if (exp_q.size() == 0) check_eq("b2b_unexpected_rvalid", 1, 0);
        else check_eq("b2b_rdata", o_rdata_a, exp_q.pop_front());
      end
    end
    check_eq("b2b_rv_count", rv_count, 4);
    check_eq("b2b_queue_empty", exp_q.size(), 0);

    // 6: reset during DATA of an A read
    i_req_a = 1'b1; i_wr_a = 1'b0; i_addr_a = 16'h1234;
    step();
    check_eq("rst_rd_gnt", o_gnt_a, 1);
    i_req_a = 1'b0;
    step();
    check_eq("rst_rd_in_data", dbg_state, 2);
    rst = 1'b1;
    step();
    check_reset_vals("rst_rd");
    rst = 1'b0;
    read_a("after_rst_rd", 16'h0003, 8'h43);

    // reset during ADDR of a B write: write still lands, strobe drops
    wr_snap = wr_cycles;
    i_req_b = 1'b1; i_wr_b = 1'b1; i_addr_b = 16'h8001; i_wdata_b = 8'h77;
    step();
    check_eq("rst_wr_strobe", o_wr, 1);
    i_req_b = 1'b0; i_wr_b = 1'b0;
    rst = 1'b1;
    step();
    check_reset_vals("rst_wr");
    rst = 1'b0;
    check_eq("rst_wr_one_cycle", wr_cycles - wr_snap, 1);
    read_a("after_rst_wr", 16'h8001, 8'h77);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
